// File: rtl/data_mover_bram_ex.sv
// BRAM0-to-BRAM1 copy engine: reads N words from a source base, passes each word
// through a fixed-latency transform pipeline, and writes it at a destination base.
module data_mover_bram_ex #(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 12,
   parameter int RD_LATENCY = 1,
   parameter int CORE_DELAY = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_run,
   input  logic [AWIDTH:0]   i_num_cnt,
   input  logic [AWIDTH-1:0] i_src_base,
   input  logic [AWIDTH-1:0] i_dst_base,
   input  logic [1:0]        i_mode,
   input  logic [DWIDTH-1:0] i_const,
   output logic              o_idle,
   output logic              o_read,
   output logic              o_write,
   output logic              o_done,
   output logic              o_err,
   output logic [AWIDTH:0]   o_wr_cnt,
   output logic [AWIDTH-1:0] addr_b0,
   output logic              ce_b0,
   output logic              we_b0,
   output logic [DWIDTH-1:0] d_b0,
   input  logic [DWIDTH-1:0] q_b0,
   output logic [AWIDTH-1:0] addr_b1,
   output logic              ce_b1,
   output logic              we_b1,
   output logic [DWIDTH-1:0] d_b1,
   input  logic [DWIDTH-1:0] q_b1
);

   localparam int L = RD_LATENCY + CORE_DELAY;
   localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      M_PASS = 2'd0,
      M_ADD  = 2'd1,
      M_XOR  = 2'd2,
      M_INV  = 2'd3
   } mode_t;

   state_t state, state_nxt;

   logic [AWIDTH:0]   num_r;
   logic [AWIDTH-1:0] src_r;
   logic [AWIDTH-1:0] dst_r;
   mode_t             mode_r;
   logic [DWIDTH-1:0] const_r;

   logic [AWIDTH:0]   rd_cnt;
   logic [AWIDTH:0]   wr_cnt;

   logic [L:1]                          vld;
   logic [L:RD_LATENCY+1][DWIDTH-1:0]   pd;
   logic [DWIDTH-1:0]                   xform;

   logic accept;
   logic rd_issue;
   logic wr_fire;

   logic unused_q_b1;
   assign unused_q_b1 = ^q_b1;

   assign accept   = (state == S_IDLE) && i_run;
   assign rd_issue = (state == S_READ);
   assign wr_fire  = vld[L];

   // NOTE: next-state logic is purely combinational; the default assignment
   // at the top keeps every path assigned so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_run) state_nxt = (i_num_cnt == '0) ? S_DONE : S_READ;
         S_READ:  if (rd_cnt == num_r - CNT_ONE) state_nxt = S_DRAIN;
         S_DRAIN: if (wr_fire && (wr_cnt == num_r - CNT_ONE)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         num_r   <= '0;
         src_r   <= '0;
         dst_r   <= '0;
         mode_r  <= M_PASS;
         const_r <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            num_r   <= i_num_cnt;
            src_r   <= i_src_base;
            dst_r   <= i_dst_base;
            mode_r  <= mode_t'(i_mode);
            const_r <= i_const;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
         end else begin
            if (rd_issue) rd_cnt <= rd_cnt + CNT_ONE;
            if (wr_fire)  wr_cnt <= wr_cnt + CNT_ONE;
         end
      end
   end

   always_comb begin
      xform = q_b0;
      case (mode_r)
         M_PASS: xform = q_b0;
         M_ADD:  xform = q_b0 + const_r;
         M_XOR:  xform = q_b0 ^ const_r;
         M_INV:  xform = ~q_b0;
         default: xform = q_b0;
      endcase
   end

   // NOTE: the pipeline is a small register chain, not a RAM, so it is cleared
   // on reset; only true memory arrays are left unreset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
         pd  <= '0;
      end else begin
         vld                <= {vld[L-1:1], rd_issue};
         pd[RD_LATENCY+1]   <= vld[RD_LATENCY] ? xform : '0;
         for (int i = RD_LATENCY + 2; i <= L; i++) begin
            pd[i] <= pd[i-1];
         end
      end
   end

   assign o_idle   = (state == S_IDLE);
   assign o_read   = (state == S_READ);
   assign o_done   = (state == S_DONE);
   assign o_err    = i_run && (state != S_IDLE);
   assign o_write  = wr_fire;
   assign o_wr_cnt = wr_cnt;

   assign ce_b0   = rd_issue;
   assign we_b0   = 1'b0;
   assign d_b0    = '0;
   assign addr_b0 = rd_issue ? (src_r + rd_cnt[AWIDTH-1:0]) : '0;

   assign ce_b1   = wr_fire;
   assign we_b1   = wr_fire;
   assign addr_b1 = wr_fire ? (dst_r + wr_cnt[AWIDTH-1:0]) : '0;
   assign d_b1    = wr_fire ? pd[L] : '0;

endmodule

// File: tb/tb_data_mover_bram_ex.sv
// Directed bench for data_mover_bram_ex: behavioural BRAMs around the DUT,
// hand-computed expectations for timing, address wrap, transforms, errors and reset.
module tb_data_mover_bram_ex;

   localparam int DW = 32;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_run;
   logic [AW:0]   i_num_cnt;
   logic [AW-1:0] i_src_base;
   logic [AW-1:0] i_dst_base;
   logic [1:0]    i_mode;
   logic [DW-1:0] i_const;
   logic          o_idle, o_read, o_write, o_done, o_err;
   logic [AW:0]   o_wr_cnt;
   logic [AW-1:0] addr_b0, addr_b1;
   logic          ce_b0, we_b0, ce_b1, we_b1;
   logic [DW-1:0] d_b0, d_b1;
   logic [DW-1:0] q_b0 = '0;
   logic [DW-1:0] q_b1;

   logic [DW-1:0] mem0 [0:(1<<AW)-1];
   logic [DW-1:0] mem1 [0:(1<<AW)-1];
   int            total_wr = 0;
   int            n_chk = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   data_mover_bram_ex dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_run      (i_run),
      .i_num_cnt  (i_num_cnt),
      .i_src_base (i_src_base),
      .i_dst_base (i_dst_base),
      .i_mode     (i_mode),
      .i_const    (i_const),
      .o_idle     (o_idle),
      .o_read     (o_read),
      .o_write    (o_write),
      .o_done     (o_done),
      .o_err      (o_err),
      .o_wr_cnt   (o_wr_cnt),
      .addr_b0    (addr_b0),
      .ce_b0      (ce_b0),
      .we_b0      (we_b0),
      .d_b0       (d_b0),
      .q_b0       (q_b0),
      .addr_b1    (addr_b1),
      .ce_b1      (ce_b1),
      .we_b1      (we_b1),
      .d_b1       (d_b1),
      .q_b1       (q_b1)
   );

   assign q_b1 = '0;

   // One-cycle-latency read port on BRAM0, write port on BRAM1.
   always @(posedge clk) begin
      if (ce_b0) q_b0 <= mem0[addr_b0];
      if (ce_b1 && we_b1) begin
         mem1[addr_b1] <= d_b1;
         total_wr++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Launches one job; scrambles the config inputs right after accept, optionally
   // pulses i_run in cycle err_at, and observes until o_done or a cycle budget.
   task automatic run_job(input int n, input int src, input int dst, input int mode,
                          input logic [DW-1:0] cnst, input int err_at,
                          output int done_cyc, output int first_wr, output int n_wr,
                          output int n_rd, output int n_err, output int err_cyc);
      int cyc;
      done_cyc = -1; first_wr = -1; n_wr = 0; n_rd = 0; n_err = 0; err_cyc = -1;
      @(negedge clk);
      i_num_cnt  = n[AW:0];
      i_src_base = src[AW-1:0];
      i_dst_base = dst[AW-1:0];
      i_mode     = mode[1:0];
      i_const    = cnst;
      i_run      = 1'b1;
      @(posedge clk);
      #1;
      i_run      = 1'b0;
      i_num_cnt  = 13'd5;
      i_src_base = 12'hABC;
      i_dst_base = 12'h123;
      i_mode     = ~mode[1:0];
      i_const    = ~cnst;
      cyc = 0;
      while (cyc < 200 && done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         i_run = (cyc == err_at);
         #1;
         if (o_err) begin
            n_err++;
            err_cyc = cyc;
         end
         if (o_write) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
         end
         if (ce_b0) n_rd++;
         if (o_done) done_cyc = cyc;
      end
      i_run = 1'b0;
   endtask

   int dc, fw, nw, nr, ne, ec;

   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         mem0[a] = a + 100;
         mem1[a] = '0;
      end
      reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0; i_src_base = '0;
      i_dst_base = '0; i_mode = '0; i_const = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_idle",  o_idle, 1);
      check("rst_read",  o_read, 0);
      check("rst_write", o_write, 0);
      check("rst_done",  o_done, 0);
      check("rst_ce",    {ce_b0, ce_b1, we_b0, we_b1}, 0);
      check("rst_wrcnt", o_wr_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // N=8 pass-through
      run_job(8, 0, 0, 0, 32'h0, -1, dc, fw, nw, nr, ne, ec);
      check("t1_done_cyc", dc, 15);
      check("t1_first_wr", fw, 7);
      check("t1_nwr", nw, 8);
      check("t1_nrd", nr, 8);
      @(negedge clk);
      check("t1_idle", o_idle, 1);
      check("t1_wrcnt", o_wr_cnt, 8);
      check("t1_m0", mem1[0], 100);
      check("t1_m3", mem1[3], 103);
      check("t1_m7", mem1[7], 107);
      check("t1_m8", mem1[8], 0);

      // address wrap, add const 1
      run_job(4, 4094, 4095, 1, 32'h1, -1, dc, fw, nw, nr, ne, ec);
      check("t2_done_cyc", dc, 11);
      check("t2_m4095", mem1[4095], 4195);
      check("t2_m0", mem1[0], 4196);
      check("t2_m1", mem1[1], 101);
      check("t2_m2", mem1[2], 102);

      // N=0
      run_job(0, 0, 0, 0, 32'h0, -1, dc, fw, nw, nr, ne, ec);
      check("t3_done_cyc", dc, 1);
      check("t3_nrd", nr, 0);
      check("t3_nwr", nw, 0);
      check("t3_wrcnt", o_wr_cnt, 0);
      @(negedge clk);
      check("t3_idle", o_idle, 1);

      // xor then invert
      run_job(3, 10, 20, 2, 32'hFFFF0000, -1, dc, fw, nw, nr, ne, ec);
      check("t4_x0", mem1[20], 32'hFFFF006E);
      check("t4_x1", mem1[21], 32'hFFFF006F);
      check("t4_x2", mem1[22], 32'hFFFF0070);
      run_job(3, 10, 30, 3, 32'h12345678, -1, dc, fw, nw, nr, ne, ec);
      check("t4_i0", mem1[30], 32'hFFFFFF91);
      check("t4_i1", mem1[31], 32'hFFFFFF90);
      check("t4_i2", mem1[32], 32'hFFFFFF8F);

      // run while busy
      run_job(10, 0, 100, 0, 32'h0, 3, dc, fw, nw, nr, ne, ec);
      check("t5_nerr", ne, 1);
      check("t5_errcyc", ec, 3);
      check("t5_nwr", nw, 10);
      check("t5_done_cyc", dc, 17);
      check("t5_m109", mem1[109], 109);

      // reset mid-job at cycle 5 of N=16
      @(negedge clk);
      i_num_cnt = 13'd16; i_src_base = 12'd200; i_dst_base = 12'd300;
      i_mode = 2'd0; i_run = 1'b1;
      @(posedge clk);
      #1;
      i_run = 1'b0;
      repeat (5) @(negedge clk);
      nw = total_wr;
      reset_n = 1'b0;
      #1;
      check("t6_idle", o_idle, 1);
      check("t6_outs", {o_read, o_write, o_done, ce_b0, ce_b1}, 0);
      check("t6_wrcnt", o_wr_cnt, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t6_no_wr", total_wr, nw);
      check("t6_m300", mem1[300], 0);

      run_job(2, 50, 60, 0, 32'h0, -1, dc, fw, nw, nr, ne, ec);
      check("t7_done_cyc", dc, 9);
      check("t7_nwr", nw, 2);
      check("t7_m60", mem1[60], 150);
      check("t7_m61", mem1[61], 151);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
